// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: CSR read-modify-write, 64-bit cycle/instret
// counters, trap entry / MRET sequencing and the fetch redirect.
module csr_trap_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic        csr_src_zero,
   output logic [31:0] csr_rdata,
   output logic        illegal_csr,
   input  logic        exc_valid,
   input  logic [3:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret,
   input  logic        instr_retire,
   input  logic [31:0] mstatus,
   output logic        exception_raised,
   output logic        is_mret,
   output logic        wr_mstatus,
   output logic [31:0] mstatus_in,
   output logic        redirect,
   output logic [31:0] redirect_pc
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [1:0]  OP_NONE = 2'b00;
   localparam logic [1:0]  OP_RW   = 2'b01;
   localparam logic [1:0]  OP_RS   = 2'b10;
   localparam logic [1:0]  OP_RC   = 2'b11;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
   localparam logic [31:0] LOW2_MASK  = 32'hFFFF_FFFC;

   state_t      state, state_next;
   logic [31:0] mtvec, mepc, mcause, mtval, mscratch;
   logic [63:0] mcycle, minstret;
   logic [63:0] mcycle_inc, minstret_inc;

   logic        in_idle, take_trap, take_mret, csr_active;
   logic        addr_known, write_req, read_only_hit, write_en;
   logic [31:0] old_val, new_val, mepc_read;

   assign in_idle    = (state == IDLE);
   assign take_trap  = in_idle & exc_valid;
   assign take_mret  = in_idle & mret & ~exc_valid;
   assign csr_active = in_idle & ~exc_valid & ~mret & (csr_op != OP_NONE);
   assign mepc_read  = mepc & LOW2_MASK;

   always_comb begin
      addr_known = 1'b1;
      old_val    = '0;
      case (csr_addr)
         A_MSTATUS:   old_val = mstatus;
         A_MISA:      old_val = MISA_VALUE;
         A_MTVEC:     old_val = mtvec;
         A_MSCRATCH:  old_val = mscratch;
         A_MEPC:      old_val = mepc_read;
         A_MCAUSE:    old_val = mcause;
         A_MTVAL:     old_val = mtval;
         A_MCYCLE:    old_val = mcycle[31:0];
         A_MCYCLEH:   old_val = mcycle[63:32];
         A_MINSTRET:  old_val = minstret[31:0];
         A_MINSTRETH: old_val = minstret[63:32];
         A_MHARTID:   old_val = '0;
         default:     addr_known = 1'b0;
      endcase
   end

   always_comb begin
      new_val = old_val;
      case (csr_op)
         OP_RW:   new_val = csr_wdata;
         OP_RS:   new_val = old_val | csr_wdata;
         OP_RC:   new_val = old_val & ~csr_wdata;
         default: new_val = old_val;
      endcase
   end

   // RS/RC with a zero source are pure reads, so they never trip the read-only check.
   assign write_req     = csr_active & addr_known & ((csr_op == OP_RW) | ~csr_src_zero);
   assign read_only_hit = (csr_addr[11:10] == 2'b11);
   assign write_en      = write_req & ~read_only_hit;

   assign csr_rdata   = addr_known ? old_val : '0;
   assign illegal_csr = rst_n & csr_active & (~addr_known | (write_req & read_only_hit));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:    state_next = (exc_valid | mret) ? HOLD : IDLE;
         HOLD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control strobes are combinational so the mstatus block can act on them this cycle.
   always_comb begin
      exception_raised = 1'b0;
      is_mret          = 1'b0;
      wr_mstatus       = 1'b0;
      mstatus_in       = '0;
      redirect         = 1'b0;
      redirect_pc      = '0;
      if (rst_n) begin
         if (take_trap) begin
            exception_raised = 1'b1;
            redirect         = 1'b1;
            redirect_pc      = mtvec;
         end else if (take_mret) begin
            is_mret     = 1'b1;
            redirect    = 1'b1;
            redirect_pc = mepc_read;
         end else if (write_en && csr_addr == A_MSTATUS) begin
            wr_mstatus = 1'b1;
            mstatus_in = new_val;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtvec    <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
         mscratch <= '0;
      end else if (take_trap) begin
         mepc   <= exc_pc;
         mcause <= {28'b0, exc_cause};
         mtval  <= exc_tval;
      end else if (write_en) begin
         case (csr_addr)
            A_MTVEC:    mtvec    <= new_val & LOW2_MASK;
            A_MSCRATCH: mscratch <= new_val;
            A_MEPC:     mepc     <= new_val;
            A_MCAUSE:   mcause   <= new_val;
            A_MTVAL:    mtval    <= new_val;
            default:    ;
         endcase
      end
   end

   assign mcycle_inc   = mcycle + 64'd1;
   assign minstret_inc = minstret + {63'b0, instr_retire};

   // A write to one half replaces it and drops any carry that half would have produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (write_en && csr_addr == A_MCYCLE)
            mcycle <= {mcycle[63:32], new_val};
         else if (write_en && csr_addr == A_MCYCLEH)
            mcycle <= {new_val, mcycle_inc[31:0]};
         else
            mcycle <= mcycle_inc;

         if (write_en && csr_addr == A_MINSTRET)
            minstret <= {minstret[63:32], new_val};
         else if (write_en && csr_addr == A_MINSTRETH)
            minstret <= {new_val, minstret_inc[31:0]};
         else
            minstret <= minstret_inc;
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: each step drives one cycle at the negedge and checks
// the combinational outputs shortly after, with expected values worked out by hand.
module tb_csr_trap_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_src_zero;
   logic [31:0] csr_rdata;
   logic        illegal_csr;
   logic        exc_valid;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        mret;
   logic        instr_retire;
   logic [31:0] mstatus;
   logic        exception_raised;
   logic        is_mret;
   logic        wr_mstatus;
   logic [31:0] mstatus_in;
   logic        redirect;
   logic [31:0] redirect_pc;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] NONE = 2'b00;
   localparam logic [1:0] RW   = 2'b01;
   localparam logic [1:0] RS   = 2'b10;
   localparam logic [1:0] RC   = 2'b11;

   csr_trap_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .csr_op           (csr_op),
      .csr_addr         (csr_addr),
      .csr_wdata        (csr_wdata),
      .csr_src_zero     (csr_src_zero),
      .csr_rdata        (csr_rdata),
      .illegal_csr      (illegal_csr),
      .exc_valid        (exc_valid),
      .exc_cause        (exc_cause),
      .exc_pc           (exc_pc),
      .exc_tval         (exc_tval),
      .mret             (mret),
      .instr_retire     (instr_retire),
      .mstatus          (mstatus),
      .exception_raised (exception_raised),
      .is_mret          (is_mret),
      .wr_mstatus       (wr_mstatus),
      .mstatus_in       (mstatus_in),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr,
                                input logic [31:0] wdata = 32'h0, input logic src_zero = 1'b0,
                                input logic exc_req = 1'b0, input logic mret_req = 1'b0,
                                input logic [3:0] cause = 4'h0, input logic [31:0] pc = 32'h0,
                                input logic [31:0] tval = 32'h0);
      @(negedge clk);
      csr_op       = op;
      csr_addr     = addr;
      csr_wdata    = wdata;
      csr_src_zero = src_zero;
      exc_valid    = exc_req;
      mret         = mret_req;
      exc_cause    = cause;
      exc_pc       = pc;
      exc_tval     = tval;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset held with every request asserted: nothing may leak out.
      rst_n        = 1'b0;
      csr_op       = RW;
      csr_addr     = 12'h300;
      csr_wdata    = 32'h1234;
      csr_src_zero = 1'b0;
      exc_valid    = 1'b1;
      exc_cause    = 4'h2;
      exc_pc       = 32'h40;
      exc_tval     = 32'h0;
      mret         = 1'b1;
      instr_retire = 1'b0;
      mstatus      = 32'h0000_0008;
      #2;
      checkOutput("rst_exception_raised", {31'b0, exception_raised}, 32'h0);
      checkOutput("rst_is_mret", {31'b0, is_mret}, 32'h0);
      checkOutput("rst_redirect", {31'b0, redirect}, 32'h0);
      checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
      checkOutput("rst_wr_mstatus", {31'b0, wr_mstatus}, 32'h0);

      @(negedge clk);
      csr_op    = NONE;
      exc_valid = 1'b0;
      mret      = 1'b0;
      rst_n     = 1'b1;
      csr_addr  = 12'h301;
      #1;
      checkOutput("misa", csr_rdata, 32'h4000_0100);
      csr_addr = 12'h305;
      #1;
      checkOutput("mtvec_reset", csr_rdata, 32'h0);
      repeat (3) @(posedge clk);
      applyStimulus(NONE, 12'hB00);
      checkOutput("mcycle_after_3", csr_rdata, 32'd3);

      applyStimulus(RW, 12'h305, 32'h8000_0103);
      checkOutput("mtvec_write_old", csr_rdata, 32'h0);
      checkOutput("mtvec_write_illegal", {31'b0, illegal_csr}, 32'h0);
      applyStimulus(NONE, 12'h305);
      checkOutput("mtvec_masked", csr_rdata, 32'h8000_0100);

      applyStimulus(RW, 12'h340, 32'h0000_F0F0);
      applyStimulus(RS, 12'h340, 32'hFFFF_0000, 1'b1);
      checkOutput("mscratch_rs_old", csr_rdata, 32'h0000_F0F0);
      applyStimulus(RC, 12'h340, 32'h0000_0030);
      checkOutput("mscratch_rs_zero_nochange", csr_rdata, 32'h0000_F0F0);
      applyStimulus(NONE, 12'h340);
      checkOutput("mscratch_rc", csr_rdata, 32'h0000_F0C0);

      // Trap entry, then the HOLD cycle must swallow new requests.
      applyStimulus(RW, 12'h305, 32'h0000_0200);
      applyStimulus(NONE, 12'h341, 32'h0, 1'b0, 1'b1, 1'b0, 4'h2, 32'h104, 32'hDEAD);
      checkOutput("trap_exception_raised", {31'b0, exception_raised}, 32'h1);
      checkOutput("trap_redirect", {31'b0, redirect}, 32'h1);
      checkOutput("trap_redirect_pc", redirect_pc, 32'h200);
      checkOutput("trap_mepc_pre", csr_rdata, 32'h0);
      applyStimulus(RW, 12'h340, 32'h1, 1'b0, 1'b1, 1'b1, 4'h5, 32'h999, 32'h1);
      checkOutput("hold_exception_raised", {31'b0, exception_raised}, 32'h0);
      checkOutput("hold_is_mret", {31'b0, is_mret}, 32'h0);
      checkOutput("hold_redirect", {31'b0, redirect}, 32'h0);
      applyStimulus(NONE, 12'h341);
      checkOutput("trap_mepc", csr_rdata, 32'h104);
      csr_addr = 12'h342;
      #1;
      checkOutput("trap_mcause", csr_rdata, 32'h2);
      csr_addr = 12'h343;
      #1;
      checkOutput("trap_mtval", csr_rdata, 32'hDEAD);
      csr_addr = 12'h340;
      #1;
      checkOutput("hold_write_dropped", csr_rdata, 32'h0000_F0C0);

      applyStimulus(RW, 12'h341, 32'h108);
      applyStimulus(NONE, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("mret_is_mret", {31'b0, is_mret}, 32'h1);
      checkOutput("mret_redirect_pc", redirect_pc, 32'h108);
      checkOutput("mret_exception_raised", {31'b0, exception_raised}, 32'h0);
      applyStimulus(NONE, 12'h000);
      applyStimulus(NONE, 12'h000, 32'h0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h10C, 32'h77);
      checkOutput("prio_exception_raised", {31'b0, exception_raised}, 32'h1);
      checkOutput("prio_is_mret", {31'b0, is_mret}, 32'h0);
      checkOutput("prio_redirect_pc", redirect_pc, 32'h200);
      applyStimulus(NONE, 12'h000);
      applyStimulus(NONE, 12'h342);
      checkOutput("prio_mcause", csr_rdata, 32'h3);

      // High half first, then low half at all-ones so the next carry is visible.
      applyStimulus(RW, 12'hB80, 32'h0);
      applyStimulus(RW, 12'hB00, 32'hFFFF_FFFF);
      applyStimulus(NONE, 12'hB00);
      checkOutput("mcycle_written", csr_rdata, 32'hFFFF_FFFF);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("mcycle_wrapped", csr_rdata, 32'h1);
      csr_addr = 12'hB80;
      #1;
      checkOutput("mcycleh_carry", csr_rdata, 32'h1);

      applyStimulus(RW, 12'hF14, 32'h55);
      checkOutput("mhartid_write_illegal", {31'b0, illegal_csr}, 32'h1);
      checkOutput("mhartid_rdata", csr_rdata, 32'h0);
      applyStimulus(RS, 12'hF14, 32'h0, 1'b1);
      checkOutput("mhartid_read_legal", {31'b0, illegal_csr}, 32'h0);
      checkOutput("mhartid_value", csr_rdata, 32'h0);

      applyStimulus(NONE, 12'hB02);
      instr_retire = 1'b1;
      repeat (2) @(posedge clk);
      applyStimulus(NONE, 12'hB02);
      instr_retire = 1'b0;
      checkOutput("minstret_count", csr_rdata, 32'h2);

      applyStimulus(RW, 12'h300, 32'h0000_1888);
      checkOutput("mstatus_wr", {31'b0, wr_mstatus}, 32'h1);
      checkOutput("mstatus_in_rw", mstatus_in, 32'h0000_1888);
      checkOutput("mstatus_read", csr_rdata, 32'h0000_0008);
      applyStimulus(RS, 12'h300, 32'h0000_0003);
      checkOutput("mstatus_in_rs", mstatus_in, 32'h0000_000B);
      applyStimulus(RC, 12'h300, 32'h0000_0008, 1'b1);
      checkOutput("mstatus_rc_zero_nowr", {31'b0, wr_mstatus}, 32'h0);

      applyStimulus(RW, 12'h7C0, 32'hFFFF_FFFF);
      checkOutput("unknown_illegal", {31'b0, illegal_csr}, 32'h1);
      checkOutput("unknown_rdata", csr_rdata, 32'h0);
      applyStimulus(NONE, 12'h7C0);
      checkOutput("unknown_noop_legal", {31'b0, illegal_csr}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and trap sequencer for the RV32I core. It decodes CSR instructions and performs their read-modify-write on mtvec, mepc, mcause, mtval, mscratch and the 64-bit cycle/instret counters. It sequences trap entry and MRET, and drives the control inputs of the mstatus register block (exception_raised, is_mret, wr_mstatus, mstatus_in). It also issues the PC redirect to fetch.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- csr_op  in  2  00 none, 01 CSRRW, 10 CSRRS, 11 CSRRC.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  rs1 value or zero-extended zimm, already selected.
- csr_src_zero  in  1  rs1/zimm field is x0/0; suppresses the write for RS/RC.
- csr_rdata  out  32  old CSR value, combinational.
- illegal_csr  out  1  unknown address, or an effective write to a read-only CSR.
- exc_valid  in  1  an exception is being reported this cycle.
- exc_cause  in  4  exception code.
- exc_pc  in  32  PC of the faulting instruction.
- exc_tval  in  32  trap value.
- mret  in  1  MRET is executing.
- instr_retire  in  1  one instruction retired this cycle.
- mstatus  in  32  current mstatus from the mstatus register block.
- exception_raised  out  1  to the mstatus block.
- is_mret  out  1  to the mstatus block.
- wr_mstatus  out  1  to the mstatus block.
- mstatus_in  out  32  new mstatus value.
- redirect  out  1  fetch must jump this cycle.
- redirect_pc  out  32  jump target.

## Operation
- Address map:
  - 0x300 mstatus is pass-through: reads return `mstatus`, writes go out on wr_mstatus/mstatus_in.
  - 0x301 misa is read-only, 0x4000_0100.
  - 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval.
  - 0xB00/0xB80 mcycle/mcycleh, 0xB02/0xB82 minstret/minstreth.
  - 0xF14 mhartid is read-only, 0.
- mtvec supports direct mode only: bits[1:0] read 0 and writes to them are ignored. mepc bits[1:0] read 0.
- New value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
- The write is effective for RW always, and for RS/RC only when csr_src_zero=0.
- Unknown address with csr_op≠0 gives illegal_csr=1, csr_rdata=0 and no write.
- An effective write to addr[11:10]=11 gives illegal_csr=1 and no write.
- FSM states:
  - IDLE: all inputs are processed.
  - HOLD: exactly one cycle after a trap or MRET. exc_valid, mret and csr_op are ignored, all strobe outputs are 0, and counters still run. HOLD always returns to IDLE.
- Priority in IDLE is exc_valid > mret > CSR op; lower-priority requests that cycle are dropped.
- Trap (IDLE with exc_valid):
  - Outputs: exception_raised=1, redirect=1, redirect_pc=mtvec.
  - At posedge: mepc←exc_pc, mcause←{28'b0,exc_cause} (bit31=0), mtval←exc_tval; go to HOLD.
- MRET (IDLE, mret, no exc_valid): is_mret=1, redirect=1, redirect_pc=mepc; go to HOLD.
- Counters:
  - mcycle is 64-bit and increments every cycle. minstret is 64-bit and increments when instr_retire=1.
  - Both wrap 2^64−1→0; a carry out of the low word increments the high word.
  - A CSR write to either half replaces that half at the same posedge instead of incrementing; the other half is unaffected and does not receive the suppressed carry.
- mstatus writes: wr_mstatus=1 and mstatus_in=new value, in the same cycle as the effective write to 0x300.

## Timing
- Reset values:
  - mtvec, mepc, mcause, mtval, mscratch, mcycle and minstret are all 0.
  - FSM is in IDLE.
  - All strobe outputs are 0 and redirect_pc=0 while rst_n=0.
- exception_raised, is_mret, wr_mstatus, mstatus_in, redirect, redirect_pc, csr_rdata and illegal_csr are combinational, valid within the cycle.
  - This lets the mstatus block's negedge update land in the same cycle.
- Internal CSRs update at the posedge ending the cycle. A read in the trap cycle returns the pre-trap value.
- Reset asserted mid-HOLD or mid-trap returns to IDLE with reset values immediately; no partial write survives.

## Test plan
- Reset, then read 0x301, 0x305 and 0xB00 -> 0x4000_0100, 0, then mcycle=N where N is the number of posedges since reset release.
- CSRRW 0x305 wdata 0x8000_0103 -> next-cycle read 0x8000_0100. CSRRS 0x340 with csr_src_zero=1 -> no change. CSRRC 0x340 clears the selected bits.
- exc_valid with cause 2, pc 0x104, tval 0xDEAD, mtvec=0x200:
  - Same cycle: exception_raised=1, redirect_pc=0x200.
  - Next cycle: mepc=0x104, mcause=2, mtval=0xDEAD; exc_valid and mret are ignored (HOLD).
- mret with mepc=0x108 -> is_mret=1, redirect_pc=0x108. A simultaneous exc_valid wins instead: exception_raised=1, is_mret=0.
- Write mcycle=0xFFFF_FFFF and mcycleh=0 -> two cycles later mcycleh=1 and mcycle=1. A write to 0xF14 -> illegal_csr=1 and the value stays 0.
- CSRRW 0x300 wdata 0x1888 -> wr_mstatus=1 and mstatus_in=0x1888 in the same cycle. Address 0x7C0 -> illegal_csr=1, csr_rdata=0.
